sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Requester-side front end for the single-port SRAM controller: owns the controller's user interface (enable pulse, op, address, write data, read data) and shares it between the CPU's instruction-fetch port and data-memory port. It arbitrates, issues one controller transaction at a time, waits the fixed access latency, captures read data, returns a one-cycle ready pulse to the winning port, and drives the pipeline stall line while any request is outstanding.

## Interface
Parameters:
- ACCESS_CYCLES, 2, rising edges from the edge on which the controller samples ctl_en to the edge on which ctl_rdata is captured (legal 1..7)

Ports:
- clk_50MHz  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  instruction-fetch request (read only), level, held until i_ready
- i_addr  in  18  fetch address
- i_rdata  out  16  fetched word, registered
- i_ready  out  1  one-cycle completion pulse for the fetch port
- d_req  in  1  data request, level, held until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  18  data address
- d_wdata  in  16  write data
- d_rdata  out  16  read word, registered
- d_ready  out  1  one-cycle completion pulse for the data port
- stall  out  1  combinational: (i_req & ~i_ready) | (d_req & ~d_ready)
- ctl_en  out  1  controller enable, one-cycle pulse per transaction
- ctl_op  out  1  0 = read, 1 = write
- ctl_addr  out  18  controller address
- ctl_wdata  out  16  controller write data
- ctl_rdata  in  16  controller read data

## Operation
- States: IDLE, BUSY, DONE; 3-bit counter cnt; 1-bit grant register (0 = I, 1 = D).
- IDLE: if d_req, grant = D, latch d_addr/d_we/d_wdata into ctl_addr/ctl_op/ctl_wdata; else if i_req, grant = I, latch i_addr, ctl_op = 0, ctl_wdata unchanged. On either, ctl_en = 1, cnt = 0, go BUSY. Otherwise stay IDLE with ctl_en = 0.
- Priority is fixed: D beats I when both are high in the same IDLE cycle (the data access belongs to the older instruction).
- BUSY: ctl_en = 0 from the first BUSY edge; cnt increments every edge; on the edge where cnt reaches ACCESS_CYCLES, capture ctl_rdata into d_rdata (grant D, read) or i_rdata (grant I); a write captures nothing. Set the granted ready, go DONE.
- DONE: the granted ready is high for exactly this cycle; next edge clears it and returns to IDLE. No issue from DONE, so a requester dropping req on the ready edge is never re-served.
- ctl_addr, ctl_op and ctl_wdata are held stable from the issue edge through the DONE cycle.
- Request inputs are sampled only in IDLE; changes during BUSY/DONE are ignored. A req dropped mid-transaction still completes and still pulses ready.
- The rdata registers hold their value until the next read capture on that port.

## Timing
- Issue on edge k (ctl_en high during cycle k..k+1); controller samples ctl_en at edge k+1; capture at edge k+1+ACCESS_CYCLES; ready high for one cycle after that edge; IDLE after the following edge.
- Default ACCESS_CYCLES = 2: capture and ready rise at edge k+3, IDLE at k+4, earliest next issue at edge k+5. Sustained throughput is one transaction per ACCESS_CYCLES+3 cycles.
- Minimum gap between ctl_en pulses is ACCESS_CYCLES+3 cycles, which guarantees the controller is idle on the next sample.
- Reset (asynchronous, any state): state IDLE, ctl_en 0, ctl_op 0, ctl_addr 0, ctl_wdata 0, i_rdata 0, d_rdata 0, i_ready 0, d_ready 0, grant 0, cnt 0.
- Reset mid-transaction aborts it with no ready pulse. A req still high after reset release is issued fresh at the first IDLE edge.
- stall follows req combinationally and falls in the ready cycle.

## Test plan
- Reset mid-BUSY: assert rst at edge k+2 of a read -> ctl_en, i_ready, d_ready, ctl_addr, i_rdata, d_rdata all 0 immediately; with d_req held, re-issue on the first edge after release.
- D read addr 18'h00123, model returns 16'hBEEF -> single ctl_en pulse with ctl_op 0 and ctl_addr 18'h00123; d_ready high exactly one cycle after edge k+3; d_rdata = 16'hBEEF and it holds afterwards.
- D write addr 18'h3FFFF data 16'hA5A5 -> ctl_op 1 and ctl_wdata 16'hA5A5 held through DONE; d_ready one cycle; d_rdata unchanged; a following read of 18'h3FFFF returns 16'hA5A5.
- i_req and d_req raised in the same cycle (i_addr 18'h00010, d_addr 18'h00200) -> D issued first, I issued 5 cycles later; stall stays high until i_ready; i_rdata and d_rdata each receive only their own data.
- i_req held high with the address advancing on each i_ready -> ctl_en pulses exactly every 5 cycles; no duplicate issue of the same address.
- ACCESS_CYCLES = 4 build -> capture and ready at edge k+5; ctl_addr stable from k through DONE.

Source files
------------

// File: rtl/sram_arbiter.sv
// Front end for the single-port SRAM controller. Shares the controller's user
// interface between the instruction-fetch and data ports with fixed priority
// to data, one transaction in flight, and a one-cycle ready pulse per access.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        i_req,
  input  logic [17:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [17:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready,
  output logic        stall,
  output logic        ctl_en,
  output logic        ctl_op,
  output logic [17:0] ctl_addr,
  output logic [15:0] ctl_wdata,
  input  logic [15:0] ctl_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [2:0] AccessCnt = 3'(ACCESS_CYCLES);
  localparam logic       GrantI    = 1'b0;
  localparam logic       GrantD    = 1'b1;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;
  logic        ctl_en_q, ctl_en_d;
  logic        ctl_op_q, ctl_op_d;
  logic [17:0] ctl_addr_q, ctl_addr_d;
  logic [15:0] ctl_wdata_q, ctl_wdata_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;

  // Next-state: issue from IDLE only, count out the access latency, then
  // spend one DONE cycle with ready high before accepting another request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    ctl_en_d    = 1'b0;
    ctl_op_d    = ctl_op_q;
    ctl_addr_d  = ctl_addr_q;
    ctl_wdata_d = ctl_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_req) begin
          // Data wins: it belongs to the older instruction in the pipeline.
          grant_d     = GrantD;
          ctl_op_d    = d_we;
          ctl_addr_d  = d_addr;
          ctl_wdata_d = d_wdata;
          ctl_en_d    = 1'b1;
          cnt_d       = 3'd0;
          state_d     = StBusy;
        end else if (i_req) begin
          grant_d    = GrantI;
          ctl_op_d   = 1'b0;
          ctl_addr_d = i_addr;
          ctl_en_d   = 1'b1;
          cnt_d      = 3'd0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == AccessCnt) begin
          if (grant_q == GrantD) begin
            if (!ctl_op_q) d_rdata_d = ctl_rdata;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = ctl_rdata;
            i_ready_d = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        // No issue here, so a requester dropping req on its ready edge is not re-served.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transaction without a ready pulse.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      grant_q     <= GrantI;
      ctl_en_q    <= 1'b0;
      ctl_op_q    <= 1'b0;
      ctl_addr_q  <= 18'd0;
      ctl_wdata_q <= 16'd0;
      i_rdata_q   <= 16'd0;
      d_rdata_q   <= 16'd0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ctl_en_q    <= ctl_en_d;
      ctl_op_q    <= ctl_op_d;
      ctl_addr_q  <= ctl_addr_d;
      ctl_wdata_q <= ctl_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  // Output mapping; stall drops in the ready cycle so the pipeline advances there.
  always_comb begin
    ctl_en    = ctl_en_q;
    ctl_op    = ctl_op_q;
    ctl_addr  = ctl_addr_q;
    ctl_wdata = ctl_wdata_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    i_ready   = i_ready_q;
    d_ready   = d_ready_q;
    stall     = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a default-latency instance driven through
// reads, writes, contention, streaming fetch and reset abort, plus a
// four-cycle-latency instance checked for its stretched ready timing.
module tb_sram_arbiter;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [17:0] i_addr = '0, d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] i_rdata, d_rdata, ctl_wdata, ctl_rdata = '0;
  logic        i_ready, d_ready, stall, ctl_en, ctl_op;
  logic [17:0] ctl_addr;

  // Second instance, ACCESS_CYCLES = 4, data port only.
  logic        i4_req = 1'b0, d4_req = 1'b0, d4_we = 1'b0;
  logic [17:0] i4_addr = '0, d4_addr = '0;
  logic [15:0] d4_wdata = '0;
  logic [15:0] i4_rdata, d4_rdata, ctl4_wdata, ctl4_rdata = '0;
  logic        i4_ready, d4_ready, stall4, ctl4_en, ctl4_op;
  logic [17:0] ctl4_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int prev_cyc = 0;
  int e0       = 0;

  // Single remembered write location for the controller model.
  logic        wr_valid = 1'b0;
  logic [17:0] wr_addr  = '0;
  logic [15:0] wr_data  = '0;

  sram_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall),
    .ctl_en(ctl_en), .ctl_op(ctl_op), .ctl_addr(ctl_addr),
    .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata)
  );

  sram_arbiter #(.ACCESS_CYCLES(4)) dut4 (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .i_req(i4_req), .i_addr(i4_addr), .i_rdata(i4_rdata), .i_ready(i4_ready),
    .d_req(d4_req), .d_we(d4_we), .d_addr(d4_addr), .d_wdata(d4_wdata),
    .d_rdata(d4_rdata), .d_ready(d4_ready), .stall(stall4),
    .ctl_en(ctl4_en), .ctl_op(ctl4_op), .ctl_addr(ctl4_addr),
    .ctl_wdata(ctl4_wdata), .ctl_rdata(ctl4_rdata)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  function automatic logic [15:0] rd(input logic [17:0] a);
    case (a)
      18'h00123: rd = 16'hBEEF;
      18'h00010: rd = 16'h1111;
      18'h00200: rd = 16'h2222;
      default:   rd = a[15:0] ^ 16'hC3C3;
    endcase
  endfunction

  // Controller model: samples ctl_en on the edge and returns data, held until the next read.
  always @(posedge clk_50MHz) begin
    cyc <= cyc + 1;
    if (ctl_en) begin
      en_cnt <= en_cnt + 1;
      if (ctl_op) begin
        wr_valid <= 1'b1;
        wr_addr  <= ctl_addr;
        wr_data  <= ctl_wdata;
      end else begin
        ctl_rdata <= (wr_valid && wr_addr == ctl_addr) ? wr_data : rd(ctl_addr);
      end
    end
    if (ctl4_en && !ctl4_op) ctl4_rdata <= rd(ctl4_addr);
  end

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_en();
    for (int t = 0; t < 30 && !ctl_en; t++) step();
    check("en_seen", 32'(ctl_en), 32'd1);
  endtask

  task automatic wait_i_ready();
    for (int t = 0; t < 30 && !i_ready; t++) step();
    check("i_ready_seen", 32'(i_ready), 32'd1);
  endtask

  initial begin
    // Reset state.
    step(); step();
    check("rst_ctl_en", 32'(ctl_en), 32'd0);
    check("rst_ctl_addr", 32'(ctl_addr), 32'd0);
    check("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    check("rst_rdata", {i_rdata, d_rdata}, 32'd0);
    #4 rst = 1'b1;
    step();

    // Data read of 0x00123.
    d_we = 1'b0; d_addr = 18'h00123; d_req = 1'b1;
    e0 = en_cnt;
    step();
    check("rd_en", 32'(ctl_en), 32'd1);
    check("rd_op", 32'(ctl_op), 32'd0);
    check("rd_addr", 32'(ctl_addr), 32'h00123);
    check("rd_stall", 32'(stall), 32'd1);
    step();
    check("rd_en_pulse", 32'(ctl_en), 32'd0);
    step();
    check("rd_ready_early", 32'(d_ready), 32'd0);
    step();
    check("rd_ready", 32'(d_ready), 32'd1);
    check("rd_data", 32'(d_rdata), 32'hBEEF);
    check("rd_stall_done", 32'(stall), 32'd0);
    d_req = 1'b0;
    step();
    check("rd_ready_one", 32'(d_ready), 32'd0);
    step(); step(); step();
    check("rd_hold", 32'(d_rdata), 32'hBEEF);
    check("rd_one_issue", 32'(en_cnt - e0), 32'd1);

    // Data write of 0x3FFFF, then read it back.
    d_we = 1'b1; d_addr = 18'h3FFFF; d_wdata = 16'hA5A5; d_req = 1'b1;
    step();
    check("wr_op", 32'(ctl_op), 32'd1);
    check("wr_wdata", 32'(ctl_wdata), 32'hA5A5);
    d_wdata = 16'h0F0F;
    step(); step(); step();
    check("wr_ready", 32'(d_ready), 32'd1);
    check("wr_op_done", 32'(ctl_op), 32'd1);
    check("wr_wdata_done", 32'(ctl_wdata), 32'hA5A5);
    check("wr_addr_done", 32'(ctl_addr), 32'h3FFFF);
    check("wr_rdata_kept", 32'(d_rdata), 32'hBEEF);
    d_req = 1'b0; d_we = 1'b0;
    step(); step();
    d_req = 1'b1;
    wait_en();
    check("rb_addr", 32'(ctl_addr), 32'h3FFFF);
    step(); step(); step();
    check("rb_ready", 32'(d_ready), 32'd1);
    check("rb_data", 32'(d_rdata), 32'hA5A5);
    d_req = 1'b0;
    step(); step();

    // Simultaneous requests: data first, fetch five cycles later.
    i_addr = 18'h00010; d_addr = 18'h00200; i_req = 1'b1; d_req = 1'b1;
    step();
    check("both_first", 32'(ctl_addr), 32'h00200);
    step(); step(); step();
    check("both_d_ready", {30'd0, i_ready, d_ready}, 32'd1);
    check("both_d_data", 32'(d_rdata), 32'h2222);
    check("both_stall_i", 32'(stall), 32'd1);
    d_req = 1'b0;
    step();
    check("both_gap", {30'd0, ctl_en, stall}, 32'd1);
    step();
    check("both_i_en", 32'(ctl_en), 32'd1);
    check("both_i_addr", 32'(ctl_addr), 32'h00010);
    step(); step(); step();
    check("both_i_ready", 32'(i_ready), 32'd1);
    check("both_i_data", 32'(i_rdata), 32'h1111);
    check("both_d_kept", 32'(d_rdata), 32'h2222);
    check("both_stall_end", 32'(stall), 32'd0);
    i_req = 1'b0;
    step(); step();

    // Streaming fetch with the address advancing on each ready.
    i_addr = 18'h00040; i_req = 1'b1;
    e0 = en_cnt;
    for (int n = 0; n < 4; n++) begin
      wait_en();
      check("st_addr", 32'(ctl_addr), 32'h40 + 32'(n));
      if (n > 0) check("st_period", 32'(cyc - prev_cyc), 32'd5);
      prev_cyc = cyc;
      wait_i_ready();
      check("st_data", 32'(i_rdata), 32'(rd(18'h00040 + 18'(n))));
      i_addr = i_addr + 18'd1;
      if (n == 3) i_req = 1'b0;
    end
    step(); step(); step(); step(); step(); step();
    check("st_no_dup", 32'(en_cnt - e0), 32'd4);

    // Reset in the middle of a data read.
    d_we = 1'b0; d_addr = 18'h00077; d_req = 1'b1;
    wait_en();
    step(); step();
    rst = 1'b0;
    #1;
    check("ab_en", 32'(ctl_en), 32'd0);
    check("ab_ready", {30'd0, i_ready, d_ready}, 32'd0);
    check("ab_addr", 32'(ctl_addr), 32'd0);
    check("ab_rdata", {i_rdata, d_rdata}, 32'd0);
    step();
    #4 rst = 1'b1;
    step();
    check("ab_reissue", 32'(ctl_en), 32'd1);
    check("ab_reissue_addr", 32'(ctl_addr), 32'h00077);
    step(); step(); step();
    check("ab_ready_new", 32'(d_ready), 32'd1);
    check("ab_data", 32'(d_rdata), 32'hC3B4);
    d_req = 1'b0;
    step();

    // Four-cycle latency build: ready at edge k+5.
    d4_addr = 18'h00123; d4_req = 1'b1;
    for (int t = 0; t < 30 && !ctl4_en; t++) step();
    check("a4_en", 32'(ctl4_en), 32'd1);
    check("a4_addr", 32'(ctl4_addr), 32'h00123);
    step(); step(); step(); step();
    check("a4_ready_early", 32'(d4_ready), 32'd0);
    check("a4_addr_busy", 32'(ctl4_addr), 32'h00123);
    step();
    check("a4_ready", 32'(d4_ready), 32'd1);
    check("a4_data", 32'(d4_rdata), 32'hBEEF);
    check("a4_addr_done", 32'(ctl4_addr), 32'h00123);
    check("a4_side", {ctl4_op, i4_ready, stall4, 13'd0, i4_rdata}, 32'd0);
    check("a4_wdata", 32'(ctl4_wdata), 32'd0);
    d4_req = 1'b0;
    step();
    check("a4_ready_one", 32'(d4_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
